// File: rtl/halut_result_arbiter.sv
// Merges the per-column-group decoder results of the HALUT matmul into one valid/ready stream.
// Each input port has its own FIFO; a round-robin arbiter drains the FIFOs into a registered output.
module halut_result_arbiter #(
  parameter int unsigned NumPorts    = 4,
  parameter int unsigned M           = 32,
  parameter int unsigned MAddrWidth  = $clog2(M),
  parameter int unsigned BufDepth    = 2,
  parameter int unsigned RowCntWidth = 16,
  localparam int unsigned PortWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumPorts-1:0][31:0]           result_i,
  input  logic [NumPorts-1:0]                 valid_i,
  input  logic [NumPorts-1:0][MAddrWidth-1:0] m_addr_i,
  input  logic                                clear_i,
  output logic [31:0]                         out_result_o,
  output logic [MAddrWidth-1:0]               out_m_addr_o,
  output logic [PortWidth-1:0]                out_port_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic                                row_done_o,
  output logic [RowCntWidth-1:0]              row_cnt_o,
  output logic [NumPorts-1:0]                 overflow_o
);

  localparam int unsigned PtrWidth    = $clog2(BufDepth);
  localparam int unsigned CntWidth    = PtrWidth + 1;
  localparam int unsigned ResCntWidth = $clog2(M) + 1;

  typedef struct packed {
    logic [31:0]           result;
    logic [MAddrWidth-1:0] m_addr;
  } entry_t;

  entry_t [NumPorts-1:0][BufDepth-1:0] mem_q, mem_d;
  logic [NumPorts-1:0][PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [NumPorts-1:0][PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NumPorts-1:0][CntWidth-1:0]   count_q, count_d;
  logic [NumPorts-1:0]                 overflow_q, overflow_d;
  logic [PortWidth-1:0]                rr_ptr_q, rr_ptr_d;
  entry_t                              out_entry_q, out_entry_d;
  logic [PortWidth-1:0]                out_port_q, out_port_d;
  logic                                out_valid_q, out_valid_d;
  logic [ResCntWidth-1:0]              res_cnt_q, res_cnt_d;
  logic [RowCntWidth-1:0]              row_cnt_q, row_cnt_d;
  logic                                row_done_q, row_done_d;

  logic                 can_load;
  logic                 handshake;
  logic                 grant_valid;
  logic [PortWidth-1:0] grant_idx;
  logic [NumPorts-1:0]  pop;
  logic [NumPorts-1:0]  push_ok;
  int unsigned          scan_idx;

  // Round-robin grant: first non-empty FIFO at or after rr_ptr_q, scanning cyclically.
  always_comb begin
    can_load    = !out_valid_q || out_ready_i;
    handshake   = out_valid_q && out_ready_i;
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    pop         = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      scan_idx = 32'(rr_ptr_q) + i;
      if (scan_idx >= NumPorts) begin
        scan_idx = scan_idx - NumPorts;
      end
      if (!grant_valid && (count_q[PortWidth'(scan_idx)] != '0)) begin
        grant_valid = 1'b1;
        grant_idx   = PortWidth'(scan_idx);
      end
    end
    if (can_load && grant_valid) begin
      pop[grant_idx] = 1'b1;
    end
  end

  // A full FIFO still accepts a push in the cycle it is popped.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push_ok    = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      push_ok[p] = valid_i[p] && ((count_q[p] < CntWidth'(BufDepth)) || pop[p]);
      if (push_ok[p]) begin
        mem_d[p][wr_ptr_q[p]] = {result_i[p], m_addr_i[p]};
        wr_ptr_d[p]           = wr_ptr_q[p] + 1'b1;
      end
      if (pop[p]) begin
        rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
      end
      case ({push_ok[p], pop[p]})
        2'b10:   count_d[p] = count_q[p] + 1'b1;
        2'b01:   count_d[p] = count_q[p] - 1'b1;
        default: count_d[p] = count_q[p];
      endcase
      if (valid_i[p] && !push_ok[p]) begin
        overflow_d[p] = 1'b1;
      end
    end
    if (clear_i) begin
      overflow_d = '0;
    end
  end

  always_comb begin
    out_entry_d = out_entry_q;
    out_port_d  = out_port_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (can_load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_entry_d = mem_q[grant_idx][rd_ptr_q[grant_idx]];
        out_port_d  = grant_idx;
        rr_ptr_d    = (32'(grant_idx) == NumPorts - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Result counter wraps at M; the wrapping handshake closes a row.
  always_comb begin
    res_cnt_d  = res_cnt_q;
    row_cnt_d  = row_cnt_q;
    row_done_d = 1'b0;
    if (clear_i) begin
      res_cnt_d = '0;
      row_cnt_d = '0;
    end else if (handshake) begin
      if (res_cnt_q == ResCntWidth'(M - 1)) begin
        res_cnt_d  = '0;
        row_cnt_d  = row_cnt_q + 1'b1;
        row_done_d = 1'b1;
      end else begin
        res_cnt_d = res_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= '0;
      rr_ptr_q    <= '0;
      out_entry_q <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      res_cnt_q   <= '0;
      row_cnt_q   <= '0;
      row_done_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      rr_ptr_q    <= rr_ptr_d;
      out_entry_q <= out_entry_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      res_cnt_q   <= res_cnt_d;
      row_cnt_q   <= row_cnt_d;
      row_done_q  <= row_done_d;
    end
  end

  assign out_result_o = out_entry_q.result;
  assign out_m_addr_o = out_entry_q.m_addr;
  assign out_port_o   = out_port_q;
  assign out_valid_o  = out_valid_q;
  assign row_done_o   = row_done_q;
  assign row_cnt_o    = row_cnt_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_halut_result_arbiter.sv
// Bench for halut_result_arbiter: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_halut_result_arbiter;

  localparam int unsigned NumPorts    = 4;
  localparam int unsigned M           = 32;
  localparam int unsigned MAddrWidth  = $clog2(M);
  localparam int unsigned BufDepth    = 2;
  localparam int unsigned RowCntWidth = 16;

  typedef struct packed {
    logic [31:0]           res;
    logic [MAddrWidth-1:0] addr;
  } item_t;

  logic                                clk_i = 1'b0;
  logic                                rst_i = 1'b1;
  logic [NumPorts-1:0][31:0]           result_i;
  logic [NumPorts-1:0]                 valid_i;
  logic [NumPorts-1:0][MAddrWidth-1:0] m_addr_i;
  logic                                clear_i;
  logic [31:0]                         out_result_o;
  logic [MAddrWidth-1:0]               out_m_addr_o;
  logic [1:0]                          out_port_o;
  logic                                out_valid_o;
  logic                                out_ready_i;
  logic                                row_done_o;
  logic [RowCntWidth-1:0]              row_cnt_o;
  logic [NumPorts-1:0]                 overflow_o;

  halut_result_arbiter #(
    .NumPorts   (NumPorts),
    .M          (M),
    .MAddrWidth (MAddrWidth),
    .BufDepth   (BufDepth),
    .RowCntWidth(RowCntWidth)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .result_i    (result_i),
    .valid_i     (valid_i),
    .m_addr_i    (m_addr_i),
    .clear_i     (clear_i),
    .out_result_o(out_result_o),
    .out_m_addr_o(out_m_addr_o),
    .out_port_o  (out_port_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .row_done_o  (row_done_o),
    .row_cnt_o   (row_cnt_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one queue per port plus the output register contents.
  item_t             mq [NumPorts][$];
  int unsigned       m_ptr, m_port, m_res_cnt, m_rows;
  logic              m_valid, m_done;
  item_t             m_item;
  logic [NumPorts-1:0] m_ovf;

  task automatic model_reset();
    for (int p = 0; p < NumPorts; p++) mq[p].delete();
    m_ptr = 0; m_port = 0; m_res_cnt = 0; m_rows = 0;
    m_valid = 1'b0; m_done = 1'b0; m_item = '0; m_ovf = '0;
  endtask

  task automatic model_step();
    bit          hs, can_load;
    int          win, ps;
    int unsigned sz [NumPorts];
    hs       = m_valid && out_ready_i;
    can_load = !m_valid || out_ready_i;
    win      = -1;
    for (int p = 0; p < NumPorts; p++) sz[p] = mq[p].size();
    if (can_load) begin
      for (int k = 0; k < NumPorts; k++) begin
        ps = (m_ptr + k) % NumPorts;
        if (win < 0 && sz[ps] > 0) win = ps;
      end
      if (win >= 0) begin
        m_item  = mq[win].pop_front();
        m_port  = win;
        m_valid = 1'b1;
        m_ptr   = (win + 1) % NumPorts;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int p = 0; p < NumPorts; p++) begin
      if (valid_i[p]) begin
        if (sz[p] < BufDepth || win == p) mq[p].push_back('{res: result_i[p], addr: m_addr_i[p]});
        else m_ovf[p] = 1'b1;
      end
    end
    m_done = 1'b0;
    if (clear_i) begin
      m_res_cnt = 0; m_rows = 0; m_ovf = '0;
    end else if (hs) begin
      m_res_cnt++;
      if (m_res_cnt == M) begin
        m_res_cnt = 0;
        m_rows    = (m_rows + 1) % (1 << RowCntWidth);
        m_done    = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check("out_valid", 64'(out_valid_o), 64'(m_valid));
    if (m_valid) begin
      check("out_result", 64'(out_result_o), 64'(m_item.res));
      check("out_m_addr", 64'(out_m_addr_o), 64'(m_item.addr));
      check("out_port", 64'(out_port_o), 64'(m_port));
    end
    check("row_done", 64'(row_done_o), 64'(m_done));
    check("row_cnt", 64'(row_cnt_o), 64'(m_rows));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    valid_i  = '0;
    result_i = '0;
    m_addr_i = '0;
    clear_i  = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    out_ready_i = 1'b1;
    repeat (12) tick();
  endtask

  task automatic pulse_clear();
    idle_inputs();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic strobe(input int p, input logic [31:0] res, input logic [MAddrWidth-1:0] addr);
    idle_inputs();
    valid_i[p]  = 1'b1;
    result_i[p] = res;
    m_addr_i[p] = addr;
  endtask

  logic [31:0] got_q [$];
  int unsigned done_cnt, valid_seen, load_pct, rdy_pct;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    out_ready_i = 1'b1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_result", 64'(out_result_o), 64'd0);
    check("rst_m_addr", 64'(out_m_addr_o), 64'd0);
    check("rst_port", 64'(out_port_o), 64'd0);
    check("rst_row_done", 64'(row_done_o), 64'd0);
    check("rst_row_cnt", 64'(row_cnt_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    rst_i = 1'b0;

    // Round-robin from a fresh pointer, twice.
    for (int r = 0; r < 2; r++) begin
      idle_inputs();
      for (int p = 0; p < NumPorts; p++) begin
        valid_i[p]  = 1'b1;
        result_i[p] = 32'h100 * (r + 1) + p;
        m_addr_i[p] = MAddrWidth'(p + 4);
      end
      tick();
      idle_inputs();
      for (int k = 0; k < NumPorts; k++) begin
        tick();
        check("rr_valid", 64'(out_valid_o), 64'd1);
        check("rr_port", 64'(out_port_o), 64'(k));
        check("rr_result", 64'(out_result_o), 64'(32'h100 * (r + 1) + k));
      end
      tick();
      check("rr_idle", 64'(out_valid_o), 64'd0);
    end

    // Single result latency.
    strobe(2, 32'h3F80_0000, MAddrWidth'(9));
    tick();
    check("single_t0_valid", 64'(out_valid_o), 64'd0);
    idle_inputs();
    tick();
    check("single_valid", 64'(out_valid_o), 64'd1);
    check("single_result", 64'(out_result_o), 64'h3F80_0000);
    check("single_m_addr", 64'(out_m_addr_o), 64'd9);
    check("single_port", 64'(out_port_o), 64'd2);
    tick();
    check("single_one_cycle", 64'(out_valid_o), 64'd0);

    // Backpressure and overflow on port 1.
    drain();
    pulse_clear();
    out_ready_i = 1'b0;
    strobe(0, 32'hDEAD_0000, '0);
    tick();
    idle_inputs();
    tick();
    strobe(1, 32'hAAAA_0001, MAddrWidth'(1)); tick();
    strobe(1, 32'hBBBB_0002, MAddrWidth'(2)); tick();
    strobe(1, 32'hCCCC_0003, MAddrWidth'(3)); tick();
    idle_inputs();
    check("ovf_set", 64'(overflow_o[1]), 64'd1);
    check("ovf_other", 64'(overflow_o[0]), 64'd0);
    out_ready_i = 1'b1;
    got_q.delete();
    repeat (6) begin
      tick();
      if (out_valid_o && out_port_o == 2'd1) got_q.push_back(out_result_o);
    end
    check("ovf_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("ovf_first", 64'(got_q[0]), 64'hAAAA_0001);
      check("ovf_second", 64'(got_q[1]), 64'hBBBB_0002);
    end
    check("ovf_sticky", 64'(overflow_o[1]), 64'd1);
    pulse_clear();
    check("ovf_cleared", 64'(overflow_o), 64'd0);

    // Push into a full FIFO in the cycle it wins.
    drain();
    pulse_clear();
    out_ready_i = 1'b0;
    strobe(0, 32'h5000_0000, '0); tick();
    idle_inputs(); tick();
    strobe(0, 32'h5000_0001, '0); tick();
    strobe(0, 32'h5000_0002, '0); tick();
    out_ready_i = 1'b1;
    strobe(0, 32'h5000_0003, '0); tick();
    idle_inputs();
    check("full_pop_ovf", 64'(overflow_o[0]), 64'd0);
    got_q.delete();
    if (out_valid_o && out_port_o == 2'd0) got_q.push_back(out_result_o);
    repeat (6) begin
      tick();
      if (out_valid_o && out_port_o == 2'd0) got_q.push_back(out_result_o);
    end
    check("full_pop_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) check("full_pop_last", 64'(got_q[2]), 64'h5000_0003);

    // Row completion over 64 handshakes.
    drain();
    pulse_clear();
    done_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      strobe(i % NumPorts, $urandom, MAddrWidth'(i));
      tick();
      if (row_done_o) done_cnt++;
      if (i == 33) check("row_cnt_after_32", 64'(row_cnt_o), 64'd1);
    end
    idle_inputs();
    repeat (4) begin
      tick();
      if (row_done_o) done_cnt++;
    end
    check("row_done_pulses", 64'(done_cnt), 64'd2);
    check("row_cnt_64", 64'(row_cnt_o), 64'd2);
    pulse_clear();
    check("row_cnt_clear", 64'(row_cnt_o), 64'd0);

    // Asynchronous reset with data in flight.
    out_ready_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      idle_inputs();
      for (int p = 0; p < NumPorts; p++) begin
        valid_i[p]  = 1'b1;
        result_i[p] = $urandom;
      end
      tick();
    end
    idle_inputs();
    tick();
    check("pre_rst_valid", 64'(out_valid_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid_o), 64'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    valid_seen = 0;
    repeat (10) begin
      tick();
      if (out_valid_o) valid_seen++;
    end
    check("no_stale", 64'(valid_seen), 64'd0);

    // Random traffic.
    for (int blk = 0; blk < 15; blk++) begin
      load_pct = $urandom_range(10, 95);
      rdy_pct  = $urandom_range(20, 100);
      for (int c = 0; c < 200; c++) begin
        for (int p = 0; p < NumPorts; p++) begin
          valid_i[p]  = ($urandom_range(0, 99) < load_pct);
          result_i[p] = $urandom;
          m_addr_i[p] = MAddrWidth'($urandom);
        end
        out_ready_i = ($urandom_range(0, 99) < rdy_pct);
        clear_i     = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/halut_result_arbiter.md
Name: halut_result_arbiter

Overview:
- Collects the per-column-group decoder results of the HALUT matmul datapath into a single output stream with a valid/ready handshake.
- Each decoder-column output (32-bit FP32 result, valid pulse, global m address) has no backpressure, so every input port gets its own small FIFO.
- A round-robin arbiter drains the FIFOs into one registered output stage.
- The block also counts emitted results per output row, tracks completed rows, and flags FIFO overflows.

Parameters:
- NumPorts, 4, number of decoder-column inputs (= M / DecoderUnits of the matmul)
- M, 32, results per output row; the row counter wraps at M
- MAddrWidth, $clog2(M), width of the m address
- BufDepth, 2, entries per input FIFO (power of two, ≥2)
- RowCntWidth, 16, width of the completed-row counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- result_i  in  [NumPorts][32]  FP32 result per port
- valid_i  in  [NumPorts]  one-cycle result strobe per port
- m_addr_i  in  [NumPorts][MAddrWidth]  global column index per port
- clear_i  in  1  synchronous clear of counters and overflow flags
- out_result_o  out  32  arbitrated result
- out_m_addr_o  out  MAddrWidth  column index of out_result_o
- out_port_o  out  $clog2(NumPorts)  source port of the current output
- out_valid_o  out  1  output valid
- out_ready_i  in  1  downstream ready
- row_done_o  out  1  one-cycle pulse when the M-th result of a row is accepted
- row_cnt_o  out  RowCntWidth  completed rows
- overflow_o  out  [NumPorts]  sticky per-port overflow flag

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset values:
  - all FIFOs empty
  - round-robin pointer = 0
  - out_valid_o = 0; out_result_o, out_m_addr_o, out_port_o = 0
  - row_done_o = 0, row_cnt_o = 0, overflow_o = 0, internal result counter = 0
  - Reset asserted mid-operation discards all buffered and in-flight data.
- Push:
  - valid_i[p] high at an edge writes {result_i[p], m_addr_i[p]} into FIFO p.
  - The push is accepted if count < BufDepth, or if FIFO p is popped in the same cycle.
  - Otherwise the data is dropped, FIFO contents are unchanged, and overflow_o[p] sets at that edge.
- Arbitration:
  - The output register may load when out_valid_o == 0 or out_ready_i == 1.
  - When it can load, the grant goes to the first non-empty FIFO at or after the pointer, scanning cyclically.
  - The winner is popped, and its data and port index load the output register; out_valid_o = 1.
  - The pointer becomes winner+1 mod NumPorts.
  - No winner while the register can load → out_valid_o = 0 next cycle.
- Latency: valid_i at edge t → earliest out_valid_o after edge t+1, i.e. 2 cycles with an idle, ready output.
  - Throughput: one result per cycle while out_ready_i = 1.
- Output stability: while out_valid_o = 1 and out_ready_i = 0, all out_* hold stable and nothing is popped.
- Ordering: results from a single port emerge in arrival order. There is no ordering guarantee across ports.
- Row counting:
  - Each handshake (out_valid_o & out_ready_i) increments the result counter (width $clog2(M)+1).
  - On the handshake that brings it to M, the counter returns to 0, row_done_o pulses on the next cycle, and row_cnt_o increments.
  - row_cnt_o wraps naturally at 2^RowCntWidth.
- clear_i:
  - Zeroes the result counter, row_cnt_o and overflow_o at the next edge.
  - Takes priority over a simultaneous increment or overflow set.
  - Does not flush the FIFOs or the output register.
- Simultaneous strobes on all ports are legal; each lands in its own FIFO.

Test Plan:
1. Single result: valid_i[2] with result 0x3F800000, m_addr 9, out_ready_i = 1 → out_valid_o two cycles later with out_result_o = 0x3F800000, out_m_addr_o = 9, out_port_o = 2, for exactly one cycle.
2. Round-robin: all four ports strobe in the same cycle with out_ready_i = 1 → ports emerge in order 0, 1, 2, 3 on consecutive cycles. A second simultaneous strobe then emerges in order 0, 1, 2, 3 again.
3. Backpressure and overflow: out_ready_i = 0, port 1 strobes 3 times with values A, B, C → overflow_o[1] = 1 after the third strobe. Releasing ready yields A and B only; overflow_o[1] stays set until clear_i.
4. Push-when-full with pop: port 0 FIFO full and port 0 winning, with a strobe in the same cycle → the strobe is accepted and overflow_o[0] stays 0.
5. Row completion: 32 handshakes → row_done_o pulses once, one cycle after the 32nd handshake, and row_cnt_o goes 0→1. 64 handshakes give row_cnt_o = 2. clear_i then zeroes row_cnt_o.
6. Reset mid-stream: assert rst_i while FIFOs hold data and out_valid_o = 1 → out_valid_o = 0 immediately. After reset is released, no stale results are emitted.
